// File: rtl/ipg_arb_pkg.sv
// Shared definitions for the IPG transmit side-channel arbiter.
//   IPG_MAX_BYTES  : largest payload an idle-block slot can carry
//   IPG_LEN_WIDTH  : default byte-count width (matches PHY rx_len/tx_len)
//   arb_state_e    : arbiter FSM states
//   onehot_to_idx  : one-hot (up to MAX_REQ bits) to binary index
package ipg_arb_pkg;

  localparam int unsigned IPG_MAX_BYTES = 7;
  localparam int unsigned IPG_LEN_WIDTH = 6;
  localparam int unsigned MAX_REQ       = 8;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  // OR-based encoder; only meaningful for a one-hot or all-zero input.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ipg_tx_arbiter_if.sv
// Bundle of the requester handshake and PHY TX IPG side-channel signals.
//   slave  modport : seen by the arbiter (requests/slot in, grant/payload out)
//   master modport : seen by the environment driving requests and slots
// Optional IPG_ARB_STATS_EN adds grant_count / abort_count.
interface ipg_tx_arbiter_if
  import ipg_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned LEN_WIDTH  = IPG_LEN_WIDTH
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          ipg_slot_valid;
  logic [LEN_WIDTH-1:0]          ipg_slot_len;
  logic                          tx_ipg_valid;
  logic [DATA_WIDTH-1:0]         tx_ipg_data;
  logic [LEN_WIDTH-1:0]          tx_ipg_len;
  logic                          lock_abort;
`ifdef IPG_ARB_STATS_EN
  logic [NUM_REQ*16-1:0]         grant_count;
  logic [7:0]                    abort_count;

  modport slave (
    input  req_valid, req_data, req_len, req_last, ipg_slot_valid, ipg_slot_len,
    output req_ready, tx_ipg_valid, tx_ipg_data, tx_ipg_len, lock_abort,
    output grant_count, abort_count
  );

  modport master (
    output req_valid, req_data, req_len, req_last, ipg_slot_valid, ipg_slot_len,
    input  req_ready, tx_ipg_valid, tx_ipg_data, tx_ipg_len, lock_abort,
    input  grant_count, abort_count
  );
`else
  modport slave (
    input  req_valid, req_data, req_len, req_last, ipg_slot_valid, ipg_slot_len,
    output req_ready, tx_ipg_valid, tx_ipg_data, tx_ipg_len, lock_abort
  );

  modport master (
    output req_valid, req_data, req_len, req_last, ipg_slot_valid, ipg_slot_len,
    input  req_ready, tx_ipg_valid, tx_ipg_data, tx_ipg_len, lock_abort
  );
`endif

endinterface

// File: rtl/ipg_rr_fit_pick.sv
// Combinational cyclic priority picker.
//   elig_i : eligibility mask
//   ptr_i  : highest-priority index for this search
//   gnt_o  : one-hot grant (first eligible at or after ptr_i, wrapping)
//   idx_o  : binary index of gnt_o
//   any_o  : some requester was picked
module ipg_rr_fit_pick
  import ipg_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IdxW-1:0]    idx_o,
  output logic               any_o
);

  always_comb begin
    int unsigned j;
    logic        found;
    gnt_o = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (32'(ptr_i) + k) % NUM_REQ;
      if (!found && elig_i[IdxW'(j)]) begin
        gnt_o[IdxW'(j)] = 1'b1;
        found           = 1'b1;
      end
    end
  end

  assign any_o = |gnt_o;
  assign idx_o = IdxW'(onehot_to_idx(MAX_REQ'(gnt_o)));

endmodule

// File: rtl/ipg_tx_arbiter.sv
// Fit-aware round-robin arbiter for the 10G PHY TX IPG side channel.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ipg_tx_arbiter_if.slave -- requester valid/data/len/last/ready,
//              PHY slot offer (ipg_slot_valid/len), registered payload
//              (tx_ipg_valid/data/len) and lock_abort pulse.
// Multi-word messages lock the channel to their owner until the last beat;
// LOCK_TIMEOUT unused offered slots abort the lock.
// Optional macro IPG_ARB_STATS_EN: grant_count / abort_count statistics.
module ipg_tx_arbiter
  import ipg_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned LEN_WIDTH    = IPG_LEN_WIDTH,
  parameter int unsigned LOCK_TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst,
  ipg_tx_arbiter_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(LOCK_TIMEOUT + 1);

  arb_state_e          state_q, state_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [CntW-1:0]     idle_cnt_q, idle_cnt_d;
  logic                abort_q, abort_d;

  logic                  tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [LEN_WIDTH-1:0]  tx_len_q, tx_len_d;

  logic [LEN_WIDTH-1:0]  len_w  [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_w [NUM_REQ];
  logic [NUM_REQ-1:0]    elig;
  logic [LEN_WIDTH-1:0]  slot_cap;

  logic [NUM_REQ-1:0]    pick_mask;
  logic [IdxW-1:0]       pick_ptr;
  logic [NUM_REQ-1:0]    pick_gnt;
  logic [IdxW-1:0]       pick_idx;
  logic                  pick_any;

  // Out-of-range slot lengths are treated as a full slot, never larger.
  assign slot_cap = (bus.ipg_slot_len > LEN_WIDTH'(IPG_MAX_BYTES)) ?
                    LEN_WIDTH'(IPG_MAX_BYTES) : bus.ipg_slot_len;

  // Eligibility folds in the slot offer and reset so req_ready is zero
  // whenever there is no slot or the block is held in reset.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign len_w[g]  = bus.req_len[g*LEN_WIDTH +: LEN_WIDTH];
    assign data_w[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign elig[g]   = !rst && bus.ipg_slot_valid && bus.req_valid[g] &&
                       (len_w[g] != '0) && (len_w[g] <= slot_cap);
  end

  ipg_rr_fit_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .elig_i (pick_mask),
    .ptr_i  (pick_ptr),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      idle_cnt_q <= '0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      idle_cnt_q <= idle_cnt_d;
      abort_q    <= abort_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    idle_cnt_d = idle_cnt_q;
    abort_d    = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          rr_ptr_d = (pick_idx == IdxW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          if (!bus.req_last[pick_idx]) begin
            state_d    = ARB_LOCKED;
            owner_d    = pick_idx;
            idle_cnt_d = '0;
          end
        end
      end
      ARB_LOCKED: begin
        if (pick_any) begin
          idle_cnt_d = '0;
          if (bus.req_last[owner_q]) state_d = ARB_IDLE;
        end else if (bus.ipg_slot_valid) begin
          // Only offered slots count; this one is the LOCK_TIMEOUT-th unused.
          if (idle_cnt_q == CntW'(LOCK_TIMEOUT - 1)) begin
            state_d    = ARB_IDLE;
            abort_d    = 1'b1;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // FSM outputs: while locked only the owner may be picked.
  always_comb begin
    pick_mask = elig;
    pick_ptr  = rr_ptr_q;
    if (state_q == ARB_LOCKED) begin
      pick_mask = elig & (NUM_REQ'(1) << owner_q);
      pick_ptr  = owner_q;
    end
  end

  assign bus.req_ready = pick_gnt;

  // Registered payload toward the PHY; data holds when nothing is sent.
  always_comb begin
    tx_valid_d = pick_any;
    tx_len_d   = pick_any ? len_w[pick_idx] : '0;
    tx_data_d  = pick_any ? data_w[pick_idx] : tx_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_len_q   <= '0;
    end else begin
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_len_q   <= tx_len_d;
    end
  end

  assign bus.tx_ipg_valid = tx_valid_q;
  assign bus.tx_ipg_data  = tx_data_q;
  assign bus.tx_ipg_len   = tx_len_q;
  assign bus.lock_abort   = abort_q;

`ifdef IPG_ARB_STATS_EN
  logic [15:0] grant_cnt_q [NUM_REQ];
  logic [7:0]  abort_cnt_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        grant_cnt_q[g] <= '0;
      end else if (pick_gnt[g] && (grant_cnt_q[g] != '1)) begin
        grant_cnt_q[g] <= grant_cnt_q[g] + 1'b1;
      end
    end
    assign bus.grant_count[g*16 +: 16] = grant_cnt_q[g];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abort_cnt_q <= '0;
    end else if (abort_d && (abort_cnt_q != '1)) begin
      abort_cnt_q <= abort_cnt_q + 1'b1;
    end
  end

  assign bus.abort_count = abort_cnt_q;
`endif

endmodule

// File: tb/tb_ipg_tx_arbiter.sv
// Directed self-checking bench for ipg_tx_arbiter (4 requesters, 64-bit words,
// LOCK_TIMEOUT=16). Inputs change after the falling edge; req_ready is sampled
// 1 time unit later and registered outputs 1 time unit after the rising edge.
module tb_ipg_tx_arbiter;

  localparam int unsigned DW = 64;
  localparam int unsigned NR = 4;
  localparam int unsigned LW = 6;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ipg_tx_arbiter_if #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .LEN_WIDTH  (LW)
  ) bus ();

  ipg_tx_arbiter #(
    .DATA_WIDTH   (DW),
    .NUM_REQ      (NR),
    .LEN_WIDTH    (LW),
    .LOCK_TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic set_req(input int i, input logic v, input logic [LW-1:0] len,
                         input logic last, input logic [DW-1:0] data);
    bus.req_valid[i]          = v;
    bus.req_len[i*LW +: LW]   = len;
    bus.req_last[i]           = last;
    bus.req_data[i*DW +: DW]  = data;
  endtask

  task automatic clear_reqs();
    bus.req_valid      = '0;
    bus.req_len        = '0;
    bus.req_last       = '0;
    bus.req_data       = '0;
    bus.ipg_slot_valid = 1'b0;
    bus.ipg_slot_len   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer a slot for the next rising edge; returns where req_ready is stable.
  task automatic offer(input logic [LW-1:0] slen);
    @(negedge clk);
    bus.ipg_slot_valid = 1'b1;
    bus.ipg_slot_len   = slen;
    #1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
    bus.ipg_slot_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 6'd3, 1'b1, 64'hFF);
    bus.ipg_slot_valid = 1'b1;
    bus.ipg_slot_len   = 6'd7;
    #2;
    n_cmp++; if (bus.req_ready !== 4'b0000) begin
      n_err++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
    n_cmp++; if (bus.tx_ipg_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_tx_valid: got %b want 0", bus.tx_ipg_valid); end
    n_cmp++; if (bus.tx_ipg_data !== 64'h0) begin
      n_err++; $display("FAIL reset_tx_data: got %h want 0", bus.tx_ipg_data); end
    n_cmp++; if (bus.tx_ipg_len !== 6'd0) begin
      n_err++; $display("FAIL reset_tx_len: got %0d want 0", bus.tx_ipg_len); end
    n_cmp++; if (bus.lock_abort !== 1'b0) begin
      n_err++; $display("FAIL reset_abort: got %b want 0", bus.lock_abort); end
    @(posedge clk); #1;
    n_cmp++; if (bus.tx_ipg_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_hold_valid: got %b want 0", bus.tx_ipg_valid); end
    do_reset();
  endtask

  task automatic test_round_robin();
    logic [3:0]    exp_rdy;
    logic [DW-1:0] exp_d;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 6'd3, 1'b1, 64'hA0 + 64'(i));
    for (int k = 0; k < 5; k++) begin
      exp_rdy = 4'b0001 << (k % 4);
      exp_d   = 64'hA0 + 64'(k % 4);
      offer(6'd7);
      n_cmp++; if (bus.req_ready !== exp_rdy) begin
        n_err++; $display("FAIL rr_ready k=%0d: got %b want %b", k, bus.req_ready, exp_rdy); end
      after_edge();
      n_cmp++; if (bus.tx_ipg_valid !== 1'b1) begin
        n_err++; $display("FAIL rr_valid k=%0d: got %b want 1", k, bus.tx_ipg_valid); end
      n_cmp++; if (bus.tx_ipg_len !== 6'd3) begin
        n_err++; $display("FAIL rr_len k=%0d: got %0d want 3", k, bus.tx_ipg_len); end
      n_cmp++; if (bus.tx_ipg_data !== exp_d) begin
        n_err++; $display("FAIL rr_data k=%0d: got %h want %h", k, bus.tx_ipg_data, exp_d); end
    end
    @(posedge clk); #1;
    n_cmp++; if (bus.tx_ipg_valid !== 1'b0 || bus.tx_ipg_len !== 6'd0) begin
      n_err++; $display("FAIL rr_noslot: got valid=%b len=%0d want 0/0",
                        bus.tx_ipg_valid, bus.tx_ipg_len); end
    n_cmp++; if (bus.tx_ipg_data !== 64'hA0) begin
      n_err++; $display("FAIL rr_data_hold: got %h want a0", bus.tx_ipg_data); end
  endtask

  task automatic test_fit_skip();
    do_reset();
    set_req(0, 1'b1, 6'd7, 1'b1, 64'hB0);
    set_req(1, 1'b1, 6'd2, 1'b1, 64'hB1);
    offer(6'd4);
    n_cmp++; if (bus.req_ready !== 4'b0010) begin
      n_err++; $display("FAIL fit_ready: got %b want 0010", bus.req_ready); end
    after_edge();
    n_cmp++; if (bus.tx_ipg_len !== 6'd2 || bus.tx_ipg_data !== 64'hB1) begin
      n_err++; $display("FAIL fit_tx: got len=%0d data=%h want 2/b1",
                        bus.tx_ipg_len, bus.tx_ipg_data); end
    offer(6'd0);
    n_cmp++; if (bus.req_ready !== 4'b0000) begin
      n_err++; $display("FAIL fit_zero_slot: got %b want 0000", bus.req_ready); end
    after_edge();
    n_cmp++; if (bus.tx_ipg_valid !== 1'b0 || bus.tx_ipg_len !== 6'd0 ||
                 bus.tx_ipg_data !== 64'hB1) begin
      n_err++; $display("FAIL fit_empty_tx: got v=%b len=%0d data=%h want 0/0/b1",
                        bus.tx_ipg_valid, bus.tx_ipg_len, bus.tx_ipg_data); end
    offer(6'd7);
    n_cmp++; if (bus.req_ready !== 4'b0001) begin
      n_err++; $display("FAIL fit_big_slot: got %b want 0001", bus.req_ready); end
    after_edge();
    n_cmp++; if (bus.tx_ipg_len !== 6'd7 || bus.tx_ipg_data !== 64'hB0) begin
      n_err++; $display("FAIL fit_big_tx: got len=%0d data=%h want 7/b0",
                        bus.tx_ipg_len, bus.tx_ipg_data); end
  endtask

  task automatic test_lock();
    do_reset();
    set_req(2, 1'b1, 6'd4, 1'b0, 64'hC0);
    offer(6'd7);
    n_cmp++; if (bus.req_ready !== 4'b0100) begin
      n_err++; $display("FAIL lock_beat0: got %b want 0100", bus.req_ready); end
    after_edge();
    n_cmp++; if (bus.tx_ipg_data !== 64'hC0 || bus.tx_ipg_len !== 6'd4) begin
      n_err++; $display("FAIL lock_tx0: got data=%h len=%0d want c0/4",
                        bus.tx_ipg_data, bus.tx_ipg_len); end
    set_req(0, 1'b1, 6'd3, 1'b1, 64'hC9);
    set_req(2, 1'b1, 6'd4, 1'b0, 64'hC1);
    @(negedge clk); #1;
    n_cmp++; if (bus.req_ready !== 4'b0000) begin
      n_err++; $display("FAIL lock_noslot: got %b want 0000", bus.req_ready); end
    // Owner does not fit; req0 would fit but must not be served.
    offer(6'd3);
    n_cmp++; if (bus.req_ready !== 4'b0000) begin
      n_err++; $display("FAIL lock_owner_only: got %b want 0000", bus.req_ready); end
    after_edge();
    n_cmp++; if (bus.tx_ipg_valid !== 1'b0) begin
      n_err++; $display("FAIL lock_skip_tx: got %b want 0", bus.tx_ipg_valid); end
    offer(6'd7);
    n_cmp++; if (bus.req_ready !== 4'b0100) begin
      n_err++; $display("FAIL lock_beat1: got %b want 0100", bus.req_ready); end
    after_edge();
    n_cmp++; if (bus.tx_ipg_data !== 64'hC1) begin
      n_err++; $display("FAIL lock_tx1: got %h want c1", bus.tx_ipg_data); end
    set_req(2, 1'b1, 6'd4, 1'b1, 64'hC2);
    offer(6'd7);
    n_cmp++; if (bus.req_ready !== 4'b0100) begin
      n_err++; $display("FAIL lock_beat2: got %b want 0100", bus.req_ready); end
    after_edge();
    n_cmp++; if (bus.tx_ipg_data !== 64'hC2) begin
      n_err++; $display("FAIL lock_tx2: got %h want c2", bus.tx_ipg_data); end
    set_req(2, 1'b0, 6'd4, 1'b0, 64'h0);
    offer(6'd7);
    n_cmp++; if (bus.req_ready !== 4'b0001) begin
      n_err++; $display("FAIL lock_release: got %b want 0001", bus.req_ready); end
    after_edge();
    n_cmp++; if (bus.tx_ipg_data !== 64'hC9 || bus.tx_ipg_len !== 6'd3) begin
      n_err++; $display("FAIL lock_release_tx: got data=%h len=%0d want c9/3",
                        bus.tx_ipg_data, bus.tx_ipg_len); end
  endtask

  task automatic test_timeout();
    do_reset();
    set_req(1, 1'b1, 6'd2, 1'b0, 64'hD1);
    offer(6'd7);
    n_cmp++; if (bus.req_ready !== 4'b0010) begin
      n_err++; $display("FAIL to_lock: got %b want 0010", bus.req_ready); end
    after_edge();
    set_req(1, 1'b0, 6'd2, 1'b0, 64'hD1);
    set_req(3, 1'b1, 6'd2, 1'b1, 64'hD3);
    for (int k = 0; k < TO - 1; k++) begin
      offer(6'd7);
      n_cmp++; if (bus.req_ready !== 4'b0000) begin
        n_err++; $display("FAIL to_ready k=%0d: got %b want 0000", k, bus.req_ready); end
      after_edge();
      n_cmp++; if (bus.lock_abort !== 1'b0 || bus.tx_ipg_len !== 6'd0) begin
        n_err++; $display("FAIL to_wait k=%0d: got abort=%b len=%0d want 0/0",
                          k, bus.lock_abort, bus.tx_ipg_len); end
    end
    // Cycles without a slot must not advance the timeout.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (bus.lock_abort !== 1'b0) begin
        n_err++; $display("FAIL to_noslot k=%0d: got %b want 0", k, bus.lock_abort); end
    end
    offer(6'd7);
    n_cmp++; if (bus.req_ready !== 4'b0000) begin
      n_err++; $display("FAIL to_last_ready: got %b want 0000", bus.req_ready); end
    after_edge();
    n_cmp++; if (bus.lock_abort !== 1'b1 || bus.tx_ipg_valid !== 1'b0) begin
      n_err++; $display("FAIL to_abort: got abort=%b valid=%b want 1/0",
                        bus.lock_abort, bus.tx_ipg_valid); end
    offer(6'd7);
    n_cmp++; if (bus.req_ready !== 4'b1000) begin
      n_err++; $display("FAIL to_next_grant: got %b want 1000", bus.req_ready); end
    after_edge();
    n_cmp++; if (bus.lock_abort !== 1'b0 || bus.tx_ipg_data !== 64'hD3) begin
      n_err++; $display("FAIL to_after: got abort=%b data=%h want 0/d3",
                        bus.lock_abort, bus.tx_ipg_data); end
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    set_req(2, 1'b1, 6'd5, 1'b0, 64'hE2);
    offer(6'd7);
    after_edge();
    n_cmp++; if (bus.tx_ipg_valid !== 1'b1) begin
      n_err++; $display("FAIL rml_pre: got %b want 1", bus.tx_ipg_valid); end
    offer(6'd7);
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0000 || bus.tx_ipg_valid !== 1'b0 ||
                 bus.tx_ipg_len !== 6'd0 || bus.tx_ipg_data !== 64'h0 ||
                 bus.lock_abort !== 1'b0) begin
      n_err++; $display("FAIL rml_async: got rdy=%b v=%b len=%0d data=%h abort=%b want zeros",
                        bus.req_ready, bus.tx_ipg_valid, bus.tx_ipg_len,
                        bus.tx_ipg_data, bus.lock_abort); end
    @(negedge clk);
    rst = 1'b0;
    bus.ipg_slot_valid = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 6'd1, 1'b1, 64'hE0 + 64'(i));
    offer(6'd7);
    n_cmp++; if (bus.req_ready !== 4'b0001) begin
      n_err++; $display("FAIL rml_restart: got %b want 0001", bus.req_ready); end
    after_edge();
    n_cmp++; if (bus.tx_ipg_data !== 64'hE0) begin
      n_err++; $display("FAIL rml_restart_tx: got %h want e0", bus.tx_ipg_data); end
  endtask

`ifdef IPG_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    set_req(0, 1'b1, 6'd1, 1'b1, 64'h55);
    for (int k = 0; k < 10; k++) begin
      offer(6'd7);
      after_edge();
    end
    n_cmp++; if (bus.grant_count[15:0] !== 16'd10) begin
      n_err++; $display("FAIL stats_grant: got %0d want 10", bus.grant_count[15:0]); end
    set_req(0, 1'b1, 6'd1, 1'b0, 64'h56);
    offer(6'd7);
    after_edge();
    set_req(0, 1'b0, 6'd1, 1'b0, 64'h56);
    for (int k = 0; k < TO; k++) begin
      offer(6'd7);
      after_edge();
    end
    n_cmp++; if (bus.abort_count !== 8'd1) begin
      n_err++; $display("FAIL stats_abort: got %0d want 1", bus.abort_count); end
    n_cmp++; if (bus.grant_count[15:0] !== 16'd11 || bus.grant_count[31:16] !== 16'd0) begin
      n_err++; $display("FAIL stats_grant2: got %0d/%0d want 11/0",
                        bus.grant_count[15:0], bus.grant_count[31:16]); end
  endtask
`endif

  initial begin
    clear_reqs();
    test_reset();
    test_round_robin();
    test_fit_skip();
    test_lock();
    test_timeout();
    test_reset_mid_lock();
`ifdef IPG_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ipg_tx_arbiter.md
Name: ipg_tx_arbiter

Overview:
- Shares the transmit inter-packet-gap (IPG) side channel of the 10G PHY between NUM_REQ on-chip requesters.
- Once per idle-block slot, the PHY TX offers the slot and the number of free bytes in it. The block picks one requester by fit-aware round-robin, handshakes one word, and presents it registered to the PHY TX.
- Multi-word messages hold the grant until the last beat. A timeout prevents a stalled owner from monopolising the channel.

Parameters:
- DATA_WIDTH, 64: IPG payload word width.
- NUM_REQ, 4: number of requesters (2..8).
- LEN_WIDTH, 6: byte-count width; matches the PHY rx_len/tx_len.
- LOCK_TIMEOUT, 16: consecutive offered slots an owner may leave unused while locked before the lock is aborted.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_len  in  NUM_REQ*LEN_WIDTH  packed valid-byte count, 1..7.
- req_last  in  NUM_REQ  word is the last of its message.
- req_ready  out  NUM_REQ  one-hot grant; a transfer happens when valid and ready are both high.
- ipg_slot_valid  in  1  PHY TX offers an idle-block slot this cycle.
- ipg_slot_len  in  LEN_WIDTH  bytes available in the offered slot, 0..7.
- tx_ipg_valid  out  1  registered payload valid.
- tx_ipg_data  out  DATA_WIDTH  registered payload.
- tx_ipg_len  out  LEN_WIDTH  registered byte count; 0 when there is no payload.
- lock_abort  out  1  one-cycle pulse when a lock times out.

Behaviour:
- Reset (async): req_ready=0, tx_ipg_valid=0, tx_ipg_data=0, tx_ipg_len=0, lock_abort=0, state=IDLE, rr_ptr=0, idle_cnt=0.
- req_ready is combinational. It is nonzero only when ipg_slot_valid=1, and it is at most one-hot.
- Eligible requester i: req_valid[i]=1, req_len_i != 0, and req_len_i <= ipg_slot_len.
- A requester whose len exceeds the slot is skipped for that slot. It is never truncated.
- IDLE state:
  - The winner is the first eligible requester at or after rr_ptr, searching cyclically.
  - On a transfer, rr_ptr becomes winner+1 modulo NUM_REQ.
  - If req_last=0, go to LOCKED with owner=winner and idle_cnt=0.
- LOCKED state:
  - Only the owner is considered.
  - Owner eligible: transfer and clear idle_cnt. If req_last=1, go to IDLE; rr_ptr was already advanced at lock entry.
  - Owner not eligible on an offered slot: no grant and idle_cnt++. When idle_cnt reaches LOCK_TIMEOUT, go to IDLE, pulse lock_abort next cycle, and clear idle_cnt. Other requesters are not served in that slot.
  - Cycles with no offered slot do not count toward the timeout.
- Output latency is 1 cycle.
  - A transfer in cycle N gives tx_ipg_valid=1 in cycle N+1, with tx_ipg_data and tx_ipg_len copied from the winner.
  - A slot without a transfer gives tx_ipg_valid=0 and tx_ipg_len=0 in N+1; tx_ipg_data holds its last value.
- ipg_slot_len=0: nothing is eligible; this counts as an unused slot when LOCKED.
- A requester that drops req_valid while locked is covered by the timeout rule only; there is no error flag.
- Back-to-back slots on every cycle are supported at full rate.

Optional Feature:
- Macro IPG_ARB_STATS_EN.
- Defined:
  - Adds output grant_count, NUM_REQ*16 bits: per-requester saturating counts of words granted.
  - Adds output abort_count, 8 bits: saturating count of lock aborts.
  - Both reset to 0.
- Undefined: neither port nor the counter logic exists.

Decomposition:
- Package ipg_arb_pkg holds:
  - IPG_MAX_BYTES=7.
  - Default LEN_WIDTH=6.
  - State enum {ARB_IDLE, ARB_LOCKED}.
  - Helper function onehot_to_idx.
- One sub-module, ipg_rr_fit_pick: combinational cyclic priority picker. Inputs are an eligibility mask and rr_ptr; outputs are a one-hot grant and its index. It is reused for NUM_REQ-generic round-robin.

Test Plan:
- Round-robin: all 4 requesters valid with len=3, slot_len=7 each cycle, rr_ptr=0 -> grants cycle 0,1,2,3,0; tx_ipg_len=3 one cycle after each grant.
- Fit skip: req0 len=7, req1 len=2, slot_len=4 -> req1 granted and req0 waits. Next slot_len=7 -> req0 granted.
- Lock: req2 sends 3 beats (last on the 3rd) while req0 is also valid -> req_ready stays on req2 for all 3 slots, then req0 is granted.
- Timeout: req1 locked, then deasserts valid, LOCK_TIMEOUT=16 -> 16 offered slots with tx_ipg_len=0, a lock_abort pulse, then req3 is granted on the next slot.
- Reset mid-lock: assert rst during LOCKED -> all outputs 0 immediately; after release, arbitration restarts at req0.
- With IPG_ARB_STATS_EN: 10 grants to req0 -> grant_count[15:0]=10; one timeout -> abort_count=1.
